bus_transaction_sequencer: RTL and testbench
============================================

Name: bus_transaction_sequencer

Overview:
- Sits between the UART command parser and the shared module register bus (dbus/abus/mbus/cbus, rsp/rsp_stat).
- Takes one decoded command at a time: write or read, with module ID, register address and data.
- Issues a single bus cycle, waits for the addressed module's acknowledge or error, or times out.
- Returns a result word plus status code to the parser for UART reply formatting.
- Guarantees one outstanding bus transaction, stable address/data lines, and bounded wait time.

Parameters:
- TIMEOUT_CYCLES, 1024: WAIT-state cycles allowed before a transaction is declared timed out; legal range 2..65535.
- ERRCNT_WIDTH, 16: width of the saturating fault counter.

Ports:
- clk  in  1  system clock (200 MHz)
- rst  in  1  asynchronous, active-high reset
- cmd_valid_in  in  1  command present
- cmd_ready_out  out  1  sequencer can accept a command
- cmd_rw_in  in  1  0 = write, 1 = read
- cmd_mod_in  in  8  target module ID
- cmd_addr_in  in  5  register address
- cmd_data_in  in  32  write data (ignored for reads)
- dbus_out  out  32  data bus
- abus_out  out  5  address bus
- mbus_out  out  8  module select bus
- cbus_out  out  8  command strobe: 0x00 idle, 0x01 write, 0x02 read
- rsp_in  in  32  module read data
- rsp_stat_in  in  8  bit0 = ack, bit1 = error, bits 7:2 reserved and ignored
- res_valid_out  out  1  result present
- res_ready_in  in  1  parser consumes result
- res_data_out  out  32  read data; 0 for writes and faults
- res_code_out  out  2  00 ok, 01 module error, 10 timeout
- fault_count_out  out  ERRCNT_WIDTH  saturating count of error plus timeout results

Behaviour:
- Reset (async, immediate):
  - State is IDLE.
  - cmd_ready_out = 1.
  - dbus_out, abus_out, mbus_out and cbus_out = 0.
  - res_valid_out = 0, res_data_out = 0, res_code_out = 00.
  - Wait counter and fault_count_out = 0.
- Reset mid-transaction aborts it: cbus_out drops to 0x00 asynchronously and no result is produced.
- IDLE:
  - cmd_ready_out = 1; all other states drive it 0.
  - On cmd_valid_in & cmd_ready_out, register mod/addr/data onto mbus/abus/dbus (dbus = 0 for reads), then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - cbus_out = 0x01 for write, 0x02 for read; goes to WAIT next cycle.
  - rsp_stat_in is ignored during ISSUE.
- WAIT:
  - cbus_out = 0x00; mbus/abus/dbus held unchanged.
  - Counter starts at 0 on WAIT entry and increments each cycle.
  - Each cycle, sample rsp_stat_in:
    - error = 1 → code 01, data 0 (error wins over a simultaneous ack).
    - ack only → code 00; data = rsp_in for reads, 0 for writes.
    - Neither, and counter = TIMEOUT_CYCLES-1 → code 10, data 0.
  - An ack or error arriving on the final counter cycle wins over timeout.
  - Any outcome → RESP; result registers loaded on the transition.
- RESP:
  - res_valid_out = 1; result held stable until res_ready_in.
  - On res_valid_out & res_ready_in: clear res_valid_out, clear mbus/abus/dbus to 0, return to IDLE.
  - Earliest new command acceptance is the cycle after the handshake.
- fault_count_out increments by 1 on entering RESP with code 01 or 10; it saturates at all-ones with no wrap.
- Latency (cycle 0 = command accept):
  - ISSUE strobe at cycle 1; WAIT begins cycle 2.
  - Ack sampled at cycle k ≥ 2 → res_valid_out at cycle k+1.
  - Minimum latency is 3 cycles; timeout gives res_valid_out at cycle TIMEOUT_CYCLES+2.
- cmd_valid_in while not in IDLE is ignored; the parser must hold it until ready.
- rsp_stat_in pulses outside WAIT are ignored and have no side effect.

Test Plan:
- Write: cmd write, mod 0x03, addr 0x0A, data 0xDEADBEEF; ack at cycle 4.
  - Required: cbus 0x01 for exactly cycle 1; mbus/abus/dbus = 03/0A/DEADBEEF through cycle 4.
  - Required: res_valid at cycle 5 with code 00, data 0.
- Read: cmd read, mod 0x05, addr 0x1F; rsp_in = 0x12345678 with ack at cycle 2.
  - Required: cbus 0x02 at cycle 1; res_valid at cycle 3, data 0x12345678, code 00; dbus = 0 throughout.
- Ack plus error together at cycle 6 → code 01, data 0, fault_count_out = 1.
- Timeout with TIMEOUT_CYCLES = 8, no response:
  - Required: res_valid at cycle 10 with code 10, fault_count_out increments.
  - Repeat with ack at cycle 9 (last WAIT cycle) → code 00.
- Backpressure: hold res_ready_in = 0 for 20 cycles with cmd_valid_in held high.
  - Required: result stable, cmd_ready_out = 0.
  - Release: new command accepted the cycle after the handshake.
- Reset mid-WAIT: assert rst at cycle 3 of a read.
  - Required: cbus/mbus/abus/dbus = 0 and res_valid = 0 immediately.
  - Required: a stray ack after reset is ignored; the next command completes normally.

Source files
------------

// File: rtl/bus_transaction_sequencer.sv
// Bridges single decoded UART commands onto the shared module register bus:
// one outstanding cycle, held address/data, bounded wait, result + status back to the parser.
module bus_transaction_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ERRCNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid_in,
  output logic                    cmd_ready_out,
  input  logic                    cmd_rw_in,
  input  logic [7:0]              cmd_mod_in,
  input  logic [4:0]              cmd_addr_in,
  input  logic [31:0]             cmd_data_in,
  output logic [31:0]             dbus_out,
  output logic [4:0]              abus_out,
  output logic [7:0]              mbus_out,
  output logic [7:0]              cbus_out,
  input  logic [31:0]             rsp_in,
  input  logic [7:0]              rsp_stat_in,
  output logic                    res_valid_out,
  input  logic                    res_ready_in,
  output logic [31:0]             res_data_out,
  output logic [1:0]              res_code_out,
  output logic [ERRCNT_WIDTH-1:0] fault_count_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [7:0]  CBUS_IDLE  = 8'h00;
  localparam logic [7:0]  CBUS_WRITE = 8'h01;
  localparam logic [7:0]  CBUS_READ  = 8'h02;
  localparam logic [1:0]  CODE_OK    = 2'b00;
  localparam logic [1:0]  CODE_ERR   = 2'b01;
  localparam logic [1:0]  CODE_TMO   = 2'b10;
  localparam logic [15:0] LAST_WAIT  = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic        rw_q;
  logic [15:0] wait_cnt;

  logic        stat_ack, stat_err, timeout_hit, wait_done;
  logic [1:0]  outcome_code;
  logic [31:0] outcome_data;
  logic        unused_stat;

  // Reserved status bits carry no meaning for this block.
  assign unused_stat  = ^rsp_stat_in[7:2];
  assign stat_ack     = rsp_stat_in[0];
  assign stat_err     = rsp_stat_in[1];
  assign timeout_hit  = (wait_cnt == LAST_WAIT);
  assign wait_done    = stat_err | stat_ack | timeout_hit;

  // Priority: error beats ack, and any response on the last cycle beats timeout.
  assign outcome_code = stat_err ? CODE_ERR : (stat_ack ? CODE_OK : CODE_TMO);
  assign outcome_data = (stat_ack && !stat_err && rw_q) ? rsp_in : 32'h0;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (cmd_valid_in)  state_next = ST_ISSUE;
      ST_ISSUE:                    state_next = ST_WAIT;
      ST_WAIT:  if (wait_done)     state_next = ST_RESP;
      ST_RESP:  if (res_ready_in)  state_next = ST_IDLE;
      default:                     state_next = ST_IDLE;
    endcase
  end

  // Strobe is decoded from state so an async reset drops it immediately.
  always_comb begin
    cmd_ready_out = 1'b0;
    cbus_out      = CBUS_IDLE;
    res_valid_out = 1'b0;
    unique case (state)
      ST_IDLE:  cmd_ready_out = 1'b1;
      ST_ISSUE: cbus_out      = rw_q ? CBUS_READ : CBUS_WRITE;
      ST_RESP:  res_valid_out = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q            <= 1'b0;
      mbus_out        <= 8'h0;
      abus_out        <= 5'h0;
      dbus_out        <= 32'h0;
      wait_cnt        <= 16'h0;
      res_data_out    <= 32'h0;
      res_code_out    <= CODE_OK;
      fault_count_out <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid_in) begin
            rw_q     <= cmd_rw_in;
            mbus_out <= cmd_mod_in;
            abus_out <= cmd_addr_in;
            dbus_out <= cmd_rw_in ? 32'h0 : cmd_data_in;
          end
        end
        ST_ISSUE: wait_cnt <= 16'h0;
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 16'd1;
          if (wait_done) begin
            res_data_out <= outcome_data;
            res_code_out <= outcome_code;
            if (outcome_code != CODE_OK && fault_count_out != '1)
              fault_count_out <= fault_count_out + ERRCNT_WIDTH'(1);
          end
        end
        ST_RESP: begin
          if (res_ready_in) begin
            mbus_out <= 8'h0;
            abus_out <= 5'h0;
            dbus_out <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_transaction_sequencer.sv
// Randomised and directed bench for bus_transaction_sequencer, checked against a
// cycle-numbered transaction model computed from the command/response schedule.
module tb_bus_transaction_sequencer;

  localparam int T = 8;
  localparam int W = 3;
  localparam int FMAX = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid_in, cmd_ready_out, cmd_rw_in;
  logic [7:0]    cmd_mod_in;
  logic [4:0]    cmd_addr_in;
  logic [31:0]   cmd_data_in;
  logic [31:0]   dbus_out;
  logic [4:0]    abus_out;
  logic [7:0]    mbus_out, cbus_out;
  logic [31:0]   rsp_in;
  logic [7:0]    rsp_stat_in;
  logic          res_valid_out, res_ready_in;
  logic [31:0]   res_data_out;
  logic [1:0]    res_code_out;
  logic [W-1:0]  fault_count_out;

  int checks = 0;
  int failures = 0;
  int fault_exp = 0;

  bus_transaction_sequencer #(.TIMEOUT_CYCLES(T), .ERRCNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out), .cmd_rw_in(cmd_rw_in),
    .cmd_mod_in(cmd_mod_in), .cmd_addr_in(cmd_addr_in), .cmd_data_in(cmd_data_in),
    .dbus_out(dbus_out), .abus_out(abus_out), .mbus_out(mbus_out), .cbus_out(cbus_out),
    .rsp_in(rsp_in), .rsp_stat_in(rsp_stat_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .res_data_out(res_data_out), .res_code_out(res_code_out),
    .fault_count_out(fault_count_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. Cycle 0 is the accepting edge; resp_cyc is the cycle in
  // which rsp_stat/rsp are presented (0 = never).
  task automatic run_txn(input string name, input logic rw, input logic [7:0] mod,
                         input logic [4:0] addr, input logic [31:0] data,
                         input int resp_cyc, input logic [7:0] stat, input logic [31:0] rsp,
                         input int hold, input logic keep_valid);
    bit          hit;
    int          vcyc;
    logic [1:0]  ecode;
    logic [31:0] edata, edbus;
    logic [7:0]  estrobe;
    int          waited;

    hit = (resp_cyc >= 2) && (resp_cyc <= T + 1) && (stat[0] || stat[1]);
    vcyc = (hit ? resp_cyc : T + 1) + 1;
    if (hit && stat[1])      begin ecode = 2'b01; edata = 32'h0; end
    else if (hit)            begin ecode = 2'b00; edata = rw ? rsp : 32'h0; end
    else                     begin ecode = 2'b10; edata = 32'h0; end
    if (ecode != 2'b00) fault_exp = (fault_exp < FMAX) ? fault_exp + 1 : FMAX;
    estrobe = rw ? 8'h02 : 8'h01;
    edbus   = rw ? 32'h0 : data;

    waited = 0;
    while (cmd_ready_out !== 1'b1 && waited < 50) begin step(); waited++; end
    checks++;
    if (cmd_ready_out !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_timeout: cmd_ready=%b expected 1", name, cmd_ready_out);
      cmd_valid_in = 1'b0;
      return;
    end

    cmd_valid_in = 1'b1; cmd_rw_in = rw; cmd_mod_in = mod;
    cmd_addr_in = addr; cmd_data_in = data;
    step();
    cmd_valid_in = 1'b0;

    for (int c = 1; c <= vcyc; c++) begin
      rsp_stat_in = (c == resp_cyc) ? stat : 8'h00;
      rsp_in      = (c == resp_cyc) ? rsp : $urandom;
      checks++;
      if (cbus_out !== ((c == 1) ? estrobe : 8'h00)) begin
        failures++;
        $display("FAIL %s cbus c=%0d: got %h expected %h", name, c, cbus_out, (c == 1) ? estrobe : 8'h00);
      end
      checks++;
      if ({mbus_out, abus_out, dbus_out} !== {mod, addr, edbus}) begin
        failures++;
        $display("FAIL %s bus c=%0d: got %h/%h/%h expected %h/%h/%h", name, c,
                 mbus_out, abus_out, dbus_out, mod, addr, edbus);
      end
      checks++;
      if (cmd_ready_out !== 1'b0) begin
        failures++;
        $display("FAIL %s busy_ready c=%0d: got %b expected 0", name, c, cmd_ready_out);
      end
      checks++;
      if (res_valid_out !== (c == vcyc)) begin
        failures++;
        $display("FAIL %s res_valid c=%0d: got %b expected %b", name, c, res_valid_out, c == vcyc);
      end
      if (c < vcyc) step();
    end

    checks++;
    if ({res_code_out, res_data_out} !== {ecode, edata}) begin
      failures++;
      $display("FAIL %s result: got code=%b data=%h expected code=%b data=%h", name,
               res_code_out, res_data_out, ecode, edata);
    end
    checks++;
    if (fault_count_out !== W'(fault_exp)) begin
      failures++;
      $display("FAIL %s fault_count: got %0d expected %0d", name, fault_count_out, fault_exp);
    end

    if (keep_valid) begin
      cmd_valid_in = 1'b1; cmd_rw_in = $urandom; cmd_mod_in = ~mod;
      cmd_addr_in = ~addr; cmd_data_in = $urandom;
    end
    for (int h = 0; h < hold; h++) begin
      res_ready_in = 1'b0;
      rsp_stat_in  = 8'($urandom);
      step();
      checks++;
      if ({res_valid_out, cmd_ready_out, res_code_out, res_data_out, mbus_out, abus_out, cbus_out}
          !== {1'b1, 1'b0, ecode, edata, mod, addr, 8'h00}) begin
        failures++;
        $display("FAIL %s hold h=%0d: valid=%b ready=%b code=%b data=%h mbus=%h abus=%h cbus=%h expected %b/%b/%b/%h/%h/%h/00",
                 name, h, res_valid_out, cmd_ready_out, res_code_out, res_data_out, mbus_out,
                 abus_out, cbus_out, 1'b1, 1'b0, ecode, edata, mod, addr);
      end
    end
    rsp_stat_in  = 8'h00;
    res_ready_in = 1'b1;
    step();
    res_ready_in = 1'b0;
    checks++;
    if ({res_valid_out, cmd_ready_out, mbus_out, abus_out, dbus_out} !== {1'b1 ^ 1'b1, 1'b1, 45'h0}) begin
      failures++;
      $display("FAIL %s after_handshake: valid=%b ready=%b bus=%h/%h/%h expected 0/1/0/0/0", name,
               res_valid_out, cmd_ready_out, mbus_out, abus_out, dbus_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid_in = 1'b0; cmd_rw_in = 1'b0; cmd_mod_in = 8'h0; cmd_addr_in = 5'h0;
    cmd_data_in = 32'h0; rsp_in = 32'h0; rsp_stat_in = 8'h0; res_ready_in = 1'b0;
    #2;
    checks++;
    if ({cmd_ready_out, res_valid_out, cbus_out, mbus_out, abus_out, dbus_out, res_data_out, res_code_out}
        !== {1'b1, 1'b0, 8'h0, 8'h0, 5'h0, 32'h0, 32'h0, 2'b00}) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b valid=%b cbus=%h mbus=%h abus=%h dbus=%h data=%h code=%b expected 1/0/0...",
               cmd_ready_out, res_valid_out, cbus_out, mbus_out, abus_out, dbus_out, res_data_out, res_code_out);
    end
    checks++;
    if (fault_count_out !== '0) begin
      failures++;
      $display("FAIL reset_fault: got %0d expected 0", fault_count_out);
    end
    step(); step();
    rst = 1'b0;
    fault_exp = 0;
    step();
  endtask

  task automatic test_write();
    run_txn("write", 1'b0, 8'h03, 5'h0A, 32'hDEADBEEF, 4, 8'h01, 32'hCAFEF00D, 0, 1'b0);
  endtask

  task automatic test_read();
    run_txn("read", 1'b1, 8'h05, 5'h1F, 32'hFFFF0000, 2, 8'h01, 32'h12345678, 0, 1'b0);
  endtask

  task automatic test_ack_err();
    run_txn("ack_err", 1'b1, 8'h11, 5'h02, 32'h0, 6, 8'h03, 32'hAAAA5555, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 1'b1, 8'h22, 5'h04, 32'h0, 0, 8'h00, 32'h0, 0, 1'b0);
    run_txn("timeout_stray_issue", 1'b0, 8'h23, 5'h05, 32'h1, 1, 8'h01, 32'h0, 0, 1'b0);
    run_txn("last_cycle_ack", 1'b1, 8'h24, 5'h06, 32'h0, T + 1, 8'h01, 32'h0BADCAFE, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn("backpressure", 1'b0, 8'h33, 5'h07, 32'h01234567, 3, 8'h01, 32'h0, 20, 1'b1);
    checks++;
    if (cbus_out !== 8'h00) begin
      failures++;
      $display("FAIL b2b_idle_cbus: got %h expected 00", cbus_out);
    end
    run_txn("b2b_next", 1'b1, 8'h34, 5'h08, 32'h0, 2, 8'h01, 32'h87654321, 0, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    cmd_valid_in = 1'b1; cmd_rw_in = 1'b1; cmd_mod_in = 8'h44; cmd_addr_in = 5'h09; cmd_data_in = 32'h0;
    step();
    cmd_valid_in = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    checks++;
    if ({cbus_out, mbus_out, abus_out, dbus_out, res_valid_out, cmd_ready_out}
        !== {8'h0, 8'h0, 5'h0, 32'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid_wait: cbus=%h mbus=%h abus=%h dbus=%h valid=%b ready=%b expected 0/0/0/0/0/1",
               cbus_out, mbus_out, abus_out, dbus_out, res_valid_out, cmd_ready_out);
    end
    fault_exp = 0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rsp_stat_in = 8'h01; rsp_in = $urandom;
      step();
      checks++;
      if ({res_valid_out, cbus_out, cmd_ready_out, fault_count_out} !== {1'b0, 8'h0, 1'b1, W'(0)}) begin
        failures++;
        $display("FAIL stray_ack i=%0d: valid=%b cbus=%h ready=%b faults=%0d expected 0/00/1/0",
                 i, res_valid_out, cbus_out, cmd_ready_out, fault_count_out);
      end
    end
    rsp_stat_in = 8'h00;
    run_txn("after_reset", 1'b1, 8'h45, 5'h0A, 32'h0, 3, 8'h01, 32'h5A5A5A5A, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_txn("random", 1'($urandom), 8'($urandom), 5'($urandom), $urandom,
              int'($urandom_range(0, T + 2)), 8'($urandom), $urandom,
              int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < FMAX + 2; n++)
      run_txn("saturate", 1'b0, 8'h66, 5'h0C, 32'h0, 2, 8'h02, 32'h0, 0, 1'b0);
    checks++;
    if (fault_count_out !== W'(FMAX)) begin
      failures++;
      $display("FAIL saturation: got %0d expected %0d", fault_count_out, FMAX);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ack_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
